fetch_unit: RTL and testbench

//   Instruction-fetch stage upstream of the instruction ROM. Holds the PC, drives the
//   16-bit byte address into the ROM, and registers the returned 32-bit word plus its PC

---
 rtl/rv_pkg.sv | 22 ++
 rtl/fetch_pc_sel.sv | 33 +++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: filler instruction, fault cause codes,
// fetch state encoding and the IF/ID register layout.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [3:0]  CAUSE_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0]  CAUSE_IACCESS_FAULT  = 4'd1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
        logic [3:0]  cause;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: trap > uret > branch/jump > sequential pc+4.
// Branches are ignored while the fetch stage sits in a fault.
module fetch_pc_sel (
    input  logic [31:0] pc,
    input  logic        in_fault,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        uret,
    input  logic [31:0] mepc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    // NOTE: every output gets a default first so no path through the
    // if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        if (trap) begin
            next_pc  = mtvec;
            redirect = 1'b1;
        end else if (uret) begin
            next_pc  = mepc;
            redirect = 1'b1;
        end else if (br_taken && !in_fault) begin
            next_pc  = br_target;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, RUN/FAULT state, IF/ID register and
// fetch-address fault check in front of a combinational instruction ROM.
module fetch_unit
    import rv_pkg::fetch_state_t, rv_pkg::RUN, rv_pkg::FAULT, rv_pkg::if_id_t,
           rv_pkg::CAUSE_IADDR_MISALIGN, rv_pkg::CAUSE_IACCESS_FAULT;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 128,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] im_addr,
    input  logic [31:0] im_rd,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        uret,
    input  logic [31:0] mepc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault,
    output logic [3:0]  if_cause
);

    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    fetch_state_t state, state_next;
    if_id_t       q, q_next;
    logic [31:0]  pc, pc_next, sel_pc;
    logic         redirect, misaligned, out_of_range;

    assign im_addr      = pc[15:0];
    assign misaligned   = pc[1:0] != 2'b00;
    assign out_of_range = pc >= ROM_BYTES;

    fetch_pc_sel u_pc_sel (
        .pc        (pc),
        .in_fault  (state == FAULT),
        .trap      (trap),
        .mtvec     (mtvec),
        .uret      (uret),
        .mepc      (mepc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .next_pc   (sel_pc),
        .redirect  (redirect)
    );

    always_comb begin
        pc_next    = pc;
        state_next = state;
        q_next     = q;
        if (redirect) begin
            pc_next    = sel_pc;
            state_next = RUN;
            q_next     = '{valid: 1'b0, instr: NOP_INSTR, pc: q.pc, fault: 1'b0, cause: 4'd0};
        end else if (state == FAULT) begin
            // The fault entry waits for decode to take it, then the slot empties.
            if (id_ready)
                q_next = '{valid: 1'b0, instr: NOP_INSTR, pc: q.pc, fault: 1'b0, cause: 4'd0};
        end else if (id_ready || !q.valid) begin
            if (misaligned || out_of_range) begin
                q_next     = '{valid: 1'b1, instr: NOP_INSTR, pc: pc, fault: 1'b1,
                               cause: misaligned ? CAUSE_IADDR_MISALIGN : CAUSE_IACCESS_FAULT};
                state_next = FAULT;
            end else begin
                q_next  = '{valid: 1'b1, instr: im_rd, pc: pc, fault: 1'b0, cause: 4'd0};
                pc_next = sel_pc;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= RUN;
            q     <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0, fault: 1'b0, cause: 4'd0};
        end else begin
            pc    <= pc_next;
            state <= state_next;
            q     <= q_next;
        end
    end

    assign if_valid = q.valid;
    assign if_instr = q.instr;
    assign if_pc    = q.pc;
    assign if_fault = q.fault;
    assign if_cause = q.cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// redirect/stall traffic, compared against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam int          ROM_WORDS = 128;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] im_addr;
    logic [31:0] im_rd;
    logic        id_ready, br_taken, trap, uret;
    logic [31:0] br_target, mtvec, mepc;
    logic        if_valid, if_fault;
    logic [31:0] if_instr, if_pc;
    logic [3:0]  if_cause;

    logic [31:0] rom [0:ROM_WORDS-1];

    int total = 0;
    int bad   = 0;

    // Behavioural model: fetch PC, fault mode and the IF/ID contents.
    logic [31:0] m_pc;
    logic        m_flt;
    logic        m_v, m_f;
    logic [31:0] m_i, m_qpc;
    logic [3:0]  m_c;

    always #5 clk = ~clk;

    assign im_rd = (im_addr[15:9] == 7'd0) ? rom[im_addr[8:2]] : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ROM_WORDS (ROM_WORDS),
        .NOP_INSTR (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .im_addr   (im_addr),
        .im_rd     (im_rd),
        .id_ready  (id_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .trap      (trap),
        .mtvec     (mtvec),
        .uret      (uret),
        .mepc      (mepc),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_fault  (if_fault),
        .if_cause  (if_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(if_valid), 32'(m_v));
        chk("instr", if_instr, m_i);
        chk("ifpc", if_pc, m_qpc);
        chk("fault", 32'(if_fault), 32'(m_f));
        chk("cause", 32'(if_cause), 32'(m_c));
        chk("im_addr", 32'(im_addr), 32'(m_pc[15:0]));
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, then
    // compare all outputs one time unit after the rising edge.
    task automatic step(input logic r, input logic id,
                        input logic bt, input logic [31:0] bta,
                        input logic tr, input logic [31:0] mt,
                        input logic ur, input logic [31:0] me);
        rst = r; id_ready = id; br_taken = bt; br_target = bta;
        trap = tr; mtvec = mt; uret = ur; mepc = me;
        if (r) begin
            m_pc = 32'h0; m_flt = 1'b0;
            m_v = 1'b0; m_i = NOP; m_qpc = 32'h0; m_f = 1'b0; m_c = 4'd0;
        end else if (tr || ur || (bt && !m_flt)) begin
            m_pc  = tr ? mt : (ur ? me : bta);
            m_flt = 1'b0;
            m_v = 1'b0; m_i = NOP; m_f = 1'b0; m_c = 4'd0;
        end else if (m_flt) begin
            if (id) begin
                m_v = 1'b0; m_i = NOP; m_f = 1'b0; m_c = 4'd0;
            end
        end else if (id || !m_v) begin
            m_v = 1'b1; m_qpc = m_pc;
            if (m_pc % 4 != 0) begin
                m_i = NOP; m_f = 1'b1; m_c = 4'd0; m_flt = 1'b1;
            end else if (m_pc >= ROM_WORDS * 4) begin
                m_i = NOP; m_f = 1'b1; m_c = 4'd1; m_flt = 1'b1;
            end else begin
                m_i = rom[m_pc / 4]; m_f = 1'b0; m_c = 4'd0;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)      return 32'($urandom_range(0, ROM_WORDS - 1)) << 2;
        else if (sel < 8) return 32'($urandom_range(0, 4 * ROM_WORDS - 1));
        else              return 32'($urandom);
    endfunction

    initial begin
        logic rr, rid, rbt, rtr, rur;
        for (int k = 0; k < ROM_WORDS; k++) rom[k] = $urandom;
        rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        trap = 1'b0; mtvec = 32'h0; uret = 1'b0; mepc = 32'h0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h80, 1, 32'h40, 0, 0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_im_addr", 32'(im_addr), 32'h0);

        // Straight-line fetch of the first four words.
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0);
            chk("seq_pc", if_pc, 32'(k * 4));
            chk("seq_instr", if_instr, rom[k]);
        end

        // Stall with pc at 0x14.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            chk("stall_pc", if_pc, 32'h10);
            chk("stall_im_addr", 32'(im_addr), 32'h14);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("resume_pc", if_pc, 32'h14);

        // Branch while decode is stalled.
        step(0, 0, 1, 32'h24, 0, 0, 0, 0);
        chk("br_bubble", 32'(if_valid), 32'd0);
        chk("br_im_addr", 32'(im_addr), 32'h24);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_pc", if_pc, 32'h24);
        chk("br_instr", if_instr, rom[9]);

        // Trap wins over simultaneous uret and branch.
        step(0, 1, 1, 32'h10, 1, 32'h44, 1, 32'h38);
        chk("prio_im_addr", 32'(im_addr), 32'h44);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("prio_instr", if_instr, rom[17]);

        // Misaligned target, frozen fault, branch ignored, trap exit.
        step(0, 1, 1, 32'h22, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_fault", 32'(if_fault), 32'd1);
        chk("mis_cause", 32'(if_cause), 32'd0);
        chk("mis_pc", if_pc, 32'h22);
        step(0, 0, 1, 32'h30, 0, 0, 0, 0);
        chk("mis_frozen", 32'(im_addr), 32'h22);
        chk("mis_held", 32'(if_fault), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("mis_consumed", 32'(if_valid), 32'd0);
        step(0, 1, 0, 0, 1, 32'h44, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("mis_exit", if_instr, rom[17]);

        // Run off the end of the ROM, then reset out of the fault.
        step(0, 1, 1, 32'h1FC, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("end_instr", if_instr, rom[127]);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("oor_cause", 32'(if_cause), 32'd1);
        chk("oor_pc", if_pc, 32'h200);
        step(0, 0, 1, 32'h8, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("oor_rst", 32'(im_addr), 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("oor_restart", if_instr, rom[0]);

        // Random stalls, redirects, faults and resets.
        for (int n = 0; n < 800; n++) begin
            rr  = ($urandom_range(0, 199) == 0);
            rid = ($urandom_range(0, 3) != 0);
            rbt = ($urandom_range(0, 7) == 0);
            rtr = ($urandom_range(0, 19) == 0);
            rur = ($urandom_range(0, 19) == 0);
            step(rr, rid, rbt, rand_target(), rtr, rand_target(), rur, rand_target());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
